// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: state encodings and default sizing.
package truth_table_sequencer_pkg;

    localparam int DEF_N_IN   = 3;
    localparam int DEF_SETTLE = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/tts_settle_timer.sv
// Loadable down-counter with a terminal flag; o_last is high once the count is 1 or less.
module tts_settle_timer #(
    parameter int CW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_last
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_last = (r_count <= CW'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every input vector of an N_IN-input, 1-output network, waits SETTLE cycles,
// samples the output and scores it against a truth table captured at start.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_table,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        fail_cnt,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic                 first_fail_valid,
    output logic [2:0]           dbg_state
);

    localparam int TW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    state_t              r_state;
    state_t              w_next;
    logic [2**N_IN-1:0]  r_table;
    logic [N_IN-1:0]     r_vec;
    logic [N_IN-1:0]     r_dut_in;
    logic [N_IN-1:0]     r_ffv;
    logic                r_ffvalid;
    logic [N_IN:0]       r_fail_cnt;
    logic [N_IN:0]       w_fail_next;
    logic                r_pass;
    logic                w_mismatch;
    logic                w_last_vec;
    logic                w_timer_last;

    // start is a single-cycle request with no ready: it is taken only when the FSM
    // sits in IDLE, and dropped (never queued) in every other state.
    tts_settle_timer #(.CW(TW)) u_settle (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (r_state == ST_APPLY),
        .i_load_val (TW'(SETTLE)),
        .i_dec      (r_state == ST_WAIT),
        .o_last     (w_timer_last)
    );

    assign w_mismatch  = (r_state == ST_SAMPLE) && (dut_y != r_table[r_vec]);
    assign w_last_vec  = (r_vec == '1);
    assign w_fail_next = r_fail_cnt + (N_IN + 1)'(w_mismatch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_APPLY;
            ST_APPLY:  w_next = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
            ST_WAIT:   if (w_timer_last) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = w_last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        dbg_state = r_state;
    end

    // pass is resolved on the final SAMPLE so it is already valid while done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_table    <= '0;
            r_vec      <= '0;
            r_dut_in   <= '0;
            r_ffv      <= '0;
            r_ffvalid  <= 1'b0;
            r_fail_cnt <= '0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_table    <= exp_table;
                        r_vec      <= '0;
                        r_ffv      <= '0;
                        r_ffvalid  <= 1'b0;
                        r_fail_cnt <= '0;
                        r_pass     <= 1'b0;
                    end
                end
                ST_APPLY: r_dut_in <= r_vec;
                ST_SAMPLE: begin
                    r_fail_cnt <= w_fail_next;
                    if (w_mismatch && !r_ffvalid) begin
                        r_ffv     <= r_vec;
                        r_ffvalid <= 1'b1;
                    end
                    if (w_last_vec) begin
                        r_pass <= (w_fail_next == '0);
                    end else begin
                        r_vec <= r_vec + N_IN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in           = r_dut_in;
    assign pass             = r_pass;
    assign fail_cnt         = r_fail_cnt;
    assign first_fail_vec   = r_ffv;
    assign first_fail_valid = r_ffvalid;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Drives two sequencers (SETTLE=2 and SETTLE=0) against a 3-input majority network.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] tbl_a, tbl_b;
    logic [2:0] dut_in_a, dut_in_b;
    logic       y_a, y_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [3:0] fcnt_a, fcnt_b;
    logic [2:0] ffv_a, ffv_b;
    logic       ffval_a, ffval_b;
    logic [2:0] st_a, st_b;

    int n_checks = 0;
    int errors   = 0;

    always #5 clk = ~clk;

    assign y_a = (dut_in_a[2] & dut_in_a[1]) | (dut_in_a[2] & dut_in_a[0]) | (dut_in_a[1] & dut_in_a[0]);
    assign y_b = (dut_in_b[2] & dut_in_b[1]) | (dut_in_b[2] & dut_in_b[0]) | (dut_in_b[1] & dut_in_b[0]);

    truth_table_sequencer #(.N_IN(3), .SETTLE(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .exp_table(tbl_a), .dut_in(dut_in_a),
        .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a), .fail_cnt(fcnt_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffval_a), .dbg_state(st_a)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .exp_table(tbl_b), .dut_in(dut_in_b),
        .dut_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail_cnt(fcnt_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffval_b), .dbg_state(st_b)
    );

    typedef struct {
        int         sel;
        logic [7:0] tbl;
        logic       exp_pass;
        logic [3:0] exp_cnt;
        logic [2:0] exp_ffv;
        logic       exp_ffval;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_tbl(input int d, input logic [7:0] v);
        if (d == 0) tbl_a = v; else tbl_b = v;
    endtask

    function automatic logic [31:0] g_done(input int d);
        return (d == 0) ? 32'(done_a) : 32'(done_b);
    endfunction

    function automatic logic [31:0] g_dut_in(input int d);
        return (d == 0) ? 32'(dut_in_a) : 32'(dut_in_b);
    endfunction

    // Starts one run and watches it; lat is the cycle offset of done from the accept cycle.
    task automatic run_vec(input int d, input logic [7:0] tbl, input bit abuse, input int rst_at,
                           output int lat, output int pulses, output int hold3);
        bit seen;
        lat = -1; pulses = 0; hold3 = 0; seen = 0;
        @(negedge clk);
        set_tbl(d, tbl);
        set_start(d, 1'b1);
        @(posedge clk);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            set_start(d, 1'b0);
            if (g_done(d) == 1) begin
                pulses++;
                if (!seen) begin
                    lat  = n + 1;
                    seen = 1;
                    if (abuse) set_start(d, 1'b1);
                end
            end
            if (g_dut_in(d) == 3) hold3++;
            if (abuse && n == 4) set_start(d, 1'b1);
            if (abuse && n == 9) set_tbl(d, 8'h00);
            if (rst_at > 0 && n == rst_at - 1) begin
                check("pre_reset_fail_cnt", 32'(fcnt_a), 32'd2);
                rst = 1'b1;
            end
            if (rst_at > 0 && n == rst_at) begin
                check("rst_state", 32'(st_a), 32'd0);
                check("rst_busy", 32'(busy_a), 32'd0);
                check("rst_dut_in", 32'(dut_in_a), 32'd0);
                check("rst_fail_cnt", 32'(fcnt_a), 32'd0);
                check("rst_ffvalid", 32'(ffval_a), 32'd0);
                rst = 1'b0;
            end
            if (rst_at > 0 && n == rst_at + 40) break;
            if (seen && n >= lat + 3) break;
        end
        @(negedge clk);
        set_start(d, 1'b0);
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat, input int pulses,
                                input int hold3);
        int s;
        s = (v.sel == 0) ? 2 : 0;
        check({tag, "_latency"}, 32'(lat), 32'(1 + 8 * (s + 2)));
        check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_hold3"}, 32'(hold3), 32'(s + 2));
        if (v.sel == 0) begin
            check({tag, "_pass"}, 32'(pass_a), 32'(v.exp_pass));
            check({tag, "_fail_cnt"}, 32'(fcnt_a), 32'(v.exp_cnt));
            check({tag, "_ffv"}, 32'(ffv_a), 32'(v.exp_ffv));
            check({tag, "_ffvalid"}, 32'(ffval_a), 32'(v.exp_ffval));
            check({tag, "_busy_after"}, 32'(busy_a), 32'd0);
            check({tag, "_state_after"}, 32'(st_a), 32'd0);
            check({tag, "_dut_in_after"}, 32'(dut_in_a), 32'd7);
        end else begin
            check({tag, "_pass"}, 32'(pass_b), 32'(v.exp_pass));
            check({tag, "_fail_cnt"}, 32'(fcnt_b), 32'(v.exp_cnt));
            check({tag, "_ffv"}, 32'(ffv_b), 32'(v.exp_ffv));
            check({tag, "_ffvalid"}, 32'(ffval_b), 32'(v.exp_ffval));
            check({tag, "_busy_after"}, 32'(busy_b), 32'd0);
            check({tag, "_state_after"}, 32'(st_b), 32'd0);
            check({tag, "_dut_in_after"}, 32'(dut_in_b), 32'd7);
        end
    endtask

    initial begin
        int lat, pulses, hold3;
        vec_t clean;

        // Majority truth table is 8'hE8 (vectors 3,5,6,7 high).
        vecs[0] = '{0, 8'hE8, 1'b1, 4'd0, 3'd0, 1'b0};
        vecs[1] = '{0, 8'hE9, 1'b0, 4'd1, 3'd0, 1'b1};
        vecs[2] = '{0, 8'h17, 1'b0, 4'd8, 3'd0, 1'b1};
        vecs[3] = '{0, 8'hE0, 1'b0, 4'd1, 3'd3, 1'b1};
        vecs[4] = '{0, 8'h00, 1'b0, 4'd4, 3'd3, 1'b1};
        vecs[5] = '{0, 8'hFF, 1'b0, 4'd4, 3'd0, 1'b1};
        vecs[6] = '{1, 8'hE8, 1'b1, 4'd0, 3'd0, 1'b0};
        vecs[7] = '{1, 8'h17, 1'b0, 4'd8, 3'd0, 1'b1};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; tbl_a = '0; tbl_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs_a", {busy_a, done_a, pass_a, fcnt_a, ffv_a, ffval_a, dut_in_a, st_a}, 32'd0);
            check("idle_busy_b", 32'(busy_b), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].sel, vecs[i].tbl, 1'b0, 0, lat, pulses, hold3);
            check_result($sformatf("vec%0d", i), vecs[i], lat, pulses, hold3);
        end

        clean = vecs[0];
        run_vec(0, 8'hE8, 1'b1, 0, lat, pulses, hold3);
        check_result("abuse", clean, lat, pulses, hold3);

        run_vec(0, 8'h17, 1'b0, 12, lat, pulses, hold3);
        check("rst_no_done", 32'(pulses), 32'd0);
        check("rst_pass_low", 32'(pass_a), 32'd0);

        run_vec(0, 8'hE8, 1'b0, 0, lat, pulses, hold3);
        check_result("after_rst", clean, lat, pulses, hold3);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Self-checking controller that sequences a small combinational gate network through every input combination, one vector at a time. It drives the network's inputs, waits a programmable settle time, samples the network's single output and compares it against a captured expected truth table. It replaces hand-written per-vector testbench stimulus with a reusable on-chip checker that sits beside any N-input, 1-output practice circuit in the codebase.

Parameters:
N_IN, 3, number of network inputs; the block walks 2**N_IN vectors.
SETTLE, 2, wait cycles between applying a vector and sampling; 0 is legal.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a run; honoured only in IDLE
exp_table  input  2**N_IN  expected output; bit k is the expected y for vector k; captured on the start cycle
dut_in  output  N_IN  registered vector driven into the network; bit N_IN-1 is the first listed input (a), bit 0 is the last (x)
dut_y  input  1  network output
busy  output  1  high from the cycle after start is accepted until DONE is exited
done  output  1  one-cycle pulse at run completion
pass  output  1  high after a run with zero mismatches; held until the next accepted start
fail_cnt  output  N_IN+1  number of mismatching vectors in the last run; saturates at 2**N_IN by construction
first_fail_vec  output  N_IN  index of the lowest mismatching vector
first_fail_valid  output  1  high if first_fail_vec holds a real mismatch

Behaviour:
- Reset, synchronous: state=IDLE; dut_in=0; busy=0; done=0; pass=0; fail_cnt=0; first_fail_vec=0; first_fail_valid=0; vector counter=0; settle counter=0; table register=0.
- FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE, start=1: capture exp_table, clear fail_cnt, first_fail_*, and pass, set vec=0, then go to APPLY. start=0 keeps the block in IDLE. All results stay frozen in IDLE.
- APPLY, 1 cycle: dut_in<=vec; load settle counter with SETTLE. Go to WAIT if SETTLE>0, otherwise go to SAMPLE.
- WAIT: decrement the counter each cycle. Leave for SAMPLE when it reaches 1, so WAIT lasts exactly SETTLE cycles.
- SAMPLE, 1 cycle: compare dut_y with table[vec].
  - On mismatch: increment fail_cnt. If first_fail_valid=0, set first_fail_vec=vec and first_fail_valid=1.
  - If vec==2**N_IN-1, go to DONE. Otherwise increment vec and go to APPLY.
- DONE, 1 cycle: done=1; pass=(fail_cnt==0, including the final SAMPLE's update); busy drops on the next cycle; return to IDLE.
- Cost per vector: SETTLE+2 cycles. If start is accepted at cycle T, done is high at cycle T + 1 + 2**N_IN*(SETTLE+2). Defaults: T+33.
- dut_in holds its last value (all ones) after a run, until the next APPLY or reset.
- start while busy: ignored, with no queueing.
- start in the DONE cycle: ignored.
- Changes on exp_table mid-run: no effect.
- rst mid-run: immediate return to IDLE with all outputs at reset values. done does not pulse.
- Vector counter: N_IN bits plus a terminal compare. No wrap-around is observable.
- fail_cnt is N_IN+1 bits wide so that an all-mismatch run, 2**N_IN, is representable.

Decomposition:
- Shared include file (truth_table_defs.vh): state encodings as localparams (IDLE=0, APPLY=1, WAIT=2, SAMPLE=3, DONE=4, 3 bits) and the default N_IN/SETTLE values.
- One natural sub-module: tts_settle_timer, a loadable down-counter with a terminal flag, reusable by other stepped controllers.
- The FSM, vector counter and result registers stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 10 cycles with start=0 -> every output is 0 and busy never rises.
- Clean run: N_IN=3, SETTLE=2, network=3-input majority, exp_table=8'b1110_1000, start at T -> done at T+33, pass=1, fail_cnt=0, first_fail_valid=0. dut_in steps 0..7, each value held 4 cycles.
- Faulty run: same network, exp_table=8'b1110_1001 -> pass=0, fail_cnt=1, first_fail_vec=0, first_fail_valid=1. All-inverted table 8'b0001_0111 -> fail_cnt=8, first_fail_vec=0.
- SETTLE=0: majority with the correct table -> done at T+17, pass=1. Each vector is held 2 cycles.
- Start abuse: start pulsed at T+5 and in the DONE cycle, and exp_table changed to 0 at T+10 -> results match the clean run, with exactly one done pulse.
- Reset mid-run: rst at T+12 -> next cycle state=IDLE, busy=0, dut_in=0, fail_cnt=0, and no done pulse. A new start then completes normally at +33.
